pipe_ctrl: RTL and testbench

Pipeline controller for the six-stage core (PC, IF, ID, EX, LS, WB). It merges per-stage stall requests into the `stall_o[5:0]` vector consumed by every inter-stage register, such as the EX/LS register, which clears when `stall[3] & !stall[4]`. It also sequences control-flow redirects: single-cycle flush for EX jumps, and a drain-then-flush sequence for traps. It sits beside the pipeline registers and drives their load/clear decisions and the PC redirect.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_stall_wdt.sv | 29 ++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: stall bit indices, FSM encoding, stall merge.
// Optional stall watchdog is enabled with PIPE_CTRL_WDT_EN.
package pipe_ctrl_pkg;

  localparam int STALL_BUS = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_LS  = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_DRAIN    = 2'd1,
    CTRL_REDIRECT = 2'd2
  } ctrl_state_e;

  // Deepest requester wins; it holds itself and every stage upstream.
  function automatic logic [STALL_BUS-1:0] stall_merge(
    input logic rif,
    input logic rid,
    input logic rex,
    input logic rls
  );
    logic [STALL_BUS-1:0] s;
    priority case (1'b1)
      rls:     s = 6'b011111;
      rex:     s = 6'b001111;
      rid:     s = 6'b000111;
      rif:     s = 6'b000011;
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// Stall watchdog: saturating count of consecutive PC-stall cycles.
// Sticky timeout flag; instantiated only under PIPE_CTRL_WDT_EN.
module stall_wdt #(
  parameter int WDT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc,
  output logic timeout
);

  localparam int W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [W-1:0] TOP = W'(WDT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (!stall_pc) begin
      cnt <= '0;
    end else begin
      if (cnt != TOP) cnt <= cnt + 1'b1;
      if (cnt >= TOP - 1'b1) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge plus jump/trap redirect sequencing.
// Define PIPE_CTRL_WDT_EN to build in the stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DRAIN_CYC  = 2,
  parameter int WDT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              stallreq_ls_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              trap_busy_o,
  output logic              stall_timeout_o
);

  localparam int CW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  ctrl_state_e       state;
  logic [CW-1:0]     drain_cnt;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] redir_q;
  logic              flush_q;
  logic              busy_q;
  logic [5:0]        merged;
  logic [5:0]        stall_int;

  assign merged = stall_merge(stallreq_if_i, stallreq_id_i,
                              stallreq_ex_i, stallreq_ls_i);

  always_comb begin
    stall_int = merged;
    if (state == CTRL_DRAIN) stall_int = merged | 6'b001111;
    if (rst) stall_int = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CTRL_RUN;
      drain_cnt <= '0;
      target    <= '0;
      redir_q   <= '0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      redir_q <= '0;
      unique case (state)
        CTRL_RUN: begin
          if (trap_req_i) begin
            target    <= trap_vec_i;
            drain_cnt <= CW'(DRAIN_CYC - 1);
            busy_q    <= 1'b1;
            state     <= CTRL_DRAIN;
          end else if (jump_req_i && !stall_int[STALL_EX]) begin
            target  <= jump_addr_i;
            redir_q <= jump_addr_i;
            flush_q <= 1'b1;
            state   <= CTRL_REDIRECT;
          end
        end
        CTRL_DRAIN: begin
          if (!stallreq_ls_i) begin
            if (drain_cnt == '0) begin
              redir_q <= target;
              flush_q <= 1'b1;
              state   <= CTRL_REDIRECT;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        CTRL_REDIRECT: begin
          busy_q <= 1'b0;
          state  <= CTRL_RUN;
        end
        default: state <= CTRL_RUN;
      endcase
    end
  end

  assign stall_o       = stall_int;
  assign flush_o       = flush_q & !rst;
  assign redirect_pc_o = rst ? '0 : redir_q;
  assign trap_busy_o   = busy_q & !rst;

`ifdef PIPE_CTRL_WDT_EN
  logic wdt_flag;

  stall_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .stall_pc(stall_int[STALL_PC]),
    .timeout (wdt_flag)
  );

  assign stall_timeout_o = wdt_flag & !rst;
`else
  // Constant 0; the expression only keeps WDT_CYCLES referenced.
  assign stall_timeout_o = (WDT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a cycle-level behavioural model.
// Define PIPE_CTRL_WDT_EN to also exercise the watchdog (WDT_CYCLES=16).
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_WDT_EN
  localparam int WDT = 16;
`else
  localparam int WDT = 1024;
`endif
  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_if = 1'b0, s_id = 1'b0;
  logic        s_ex = 1'b0, s_ls = 1'b0;
  logic        jreq = 1'b0, treq = 1'b0;
  logic [31:0] jaddr = '0, tvec = '0;
  logic [5:0]  stall;
  logic        flush, busy, tmo;
  logic [31:0] rpc;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  bit          m_flush, m_drain, m_busy, m_to;
  int          m_left, m_run;
  logic [31:0] m_tgt, m_pc;

  pipe_ctrl #(
    .ADDR_W    (32),
    .DRAIN_CYC (DRAIN),
    .WDT_CYCLES(WDT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (s_if),
    .stallreq_id_i  (s_id),
    .stallreq_ex_i  (s_ex),
    .stallreq_ls_i  (s_ls),
    .jump_req_i     (jreq),
    .jump_addr_i    (jaddr),
    .trap_req_i     (treq),
    .trap_vec_i     (tvec),
    .stall_o        (stall),
    .flush_o        (flush),
    .redirect_pc_o  (rpc),
    .trap_busy_o    (busy),
    .stall_timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [5:0] merge_model(bit i, d, e, l);
    int depth;
    depth = l ? 4 : e ? 3 : d ? 2 : i ? 1 : 0;
    return (depth == 0) ? 6'd0 : 6'((1 << (depth + 1)) - 1);
  endfunction

  task automatic step(input bit r, i, d, e, l,
                      input bit j, input logic [31:0] ja,
                      input bit t, input logic [31:0] tv);
    logic [5:0] es;
    @(posedge clk);
    #1;
    rst = r; s_if = i; s_id = d; s_ex = e; s_ls = l;
    jreq = j; jaddr = ja; treq = t; tvec = tv;
    es = merge_model(i, d, e, l);
    if (m_drain) es = es | 6'h0f;
    if (r) es = 6'd0;
    #3;
    check("stall", 64'(stall), 64'(es));
    check("flush", 64'(flush), r ? 64'd0 : 64'(m_flush));
    check("rpc", 64'(rpc), r ? 64'd0 : 64'(m_pc));
    check("busy", 64'(busy), r ? 64'd0 : 64'(m_busy));
    check("tmo", 64'(tmo), r ? 64'd0 : 64'(m_to));
    cyc++;
    if (r) begin
      m_flush = 0; m_drain = 0; m_busy = 0; m_to = 0;
      m_left = 0; m_run = 0; m_tgt = '0; m_pc = '0;
      return;
    end
`ifdef PIPE_CTRL_WDT_EN
    if (es[0]) begin
      if (m_run < WDT - 1) m_run++;
      if (m_run >= WDT - 1) m_to = 1;
    end else begin
      m_run = 0;
    end
`endif
    if (m_flush) begin
      m_flush = 0; m_pc = '0; m_busy = 0;
    end else if (m_drain) begin
      if (!l) begin
        m_left--;
        if (m_left == 0) begin
          m_drain = 0; m_flush = 1; m_pc = m_tgt;
        end
      end
    end else if (t) begin
      m_drain = 1; m_left = DRAIN; m_tgt = tv; m_busy = 1;
    end else if (j && !es[3]) begin
      m_flush = 1; m_pc = ja;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_flush = 0; m_drain = 0; m_busy = 0; m_to = 0;
    m_left = 0; m_run = 0; m_tgt = '0; m_pc = '0;
    step(1, 1, 1, 1, 1, 1, 32'h1234, 1, 32'h5678);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // stall merge, deepest first
    step(0, 0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // plain jump
    step(0, 0, 0, 0, 0, 1, 32'h8000_0040, 0, 0);
    idle(3);
    // jump held while EX stalls
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 1, 0, 1, 32'h8000_0080, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h8000_0080, 0, 0);
    idle(3);
    // trap with two LS stall cycles in the drain
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(5);
    // trap and jump together
    step(0, 0, 0, 0, 0, 1, 32'h200, 1, 32'h300);
    idle(5);
    // reset during drain
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h400);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
`ifdef PIPE_CTRL_WDT_EN
    for (int k = 0; k < WDT; k++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
`endif
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 25,
           $urandom,
           $urandom_range(0, 99) < 6,
           $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
